// File: rtl/fir4_avg_fifo.sv
// FIR output stage: suppresses post-reset pipeline fill, averages each
// 4-sample window sum with round-half-up, and buffers results in a show-ahead FIFO.
module fir4_avg_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8,
   parameter int FILL  = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [W+1:0]             s_in,
   output logic [W-1:0]             out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     fill_done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = (FILL < 1) ? 1 : $clog2(FILL + 1);

   logic [W-1:0]  mem [DEPTH];

   logic [FW-1:0] fill_q, fill_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    drop_q, drop_d;

   logic [W+2:0]  sum_ext;
   logic [W-1:0]  avg;
   logic          pop, full, push_ok, drop;

   // Averaging is done one bit wider than s_in so the +2 rounding term cannot wrap.
   assign sum_ext = {1'b0, s_in} + (W+3)'(2);
   assign avg     = sum_ext[W+1:2];

   assign fill_done = (fill_q == FW'(FILL));
   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem[rd_q] : '0;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign drop_cnt  = drop_q;

   assign pop     = out_valid & out_ready;
   assign full    = (count_q == CW'(DEPTH));
   assign push_ok = fill_done & (~full | pop);
   assign drop    = fill_done & ~push_ok;

   always_comb begin
      fill_d  = fill_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;

      if (!fill_done)
         fill_d = fill_q + FW'(1);
      if (push_ok)
         wr_d = wr_q + AW'(1);
      if (pop)
         rd_d = rd_q + AW'(1);

      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fill_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         fill_q  <= fill_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // When full and popping, wr_q == rd_q: the head is consumed on this edge,
   // so overwriting its slot with the new tail entry is safe.
   always_ff @(posedge clk) begin
      if (reset && push_ok)
         mem[wr_q] <= avg;
   end

endmodule

// File: doc/fir4_avg_fifo.md
# fir4_avg_fifo

Output stage that sits directly downstream of the 4-tap moving-sum FIR. It consumes the FIR's registered (W+2)-bit window sum every clock and suppresses the pipeline-fill samples that follow reset. It divides each full-window sum by 4 with round-half-up and buffers the W-bit averages in a show-ahead FIFO, which the consumer drains through a valid/ready handshake. Overflow is flagged and counted rather than stalling the FIR, which has no back-pressure.

## Interface
- W, 16: FIR input sample width; output data width.
- DEPTH, 8: FIFO entries; power of 2, ≥ 2.
- FILL, 5: number of clock edges after reset release before `s_in` holds a full 4-sample window.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset); sampled on posedge clk only.
- s_in  in  W+2  window sum from the FIR `s` output; sampled every posedge.
- out_data  out  W  FIFO head (rounded average); forced 0 when out_valid = 0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- fill_done  out  1  fill counter has reached FILL.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; set on the first dropped sample.
- drop_cnt  out  8  number of dropped samples; saturates at 255.

## Operation
- Fill counter: reset → 0. It increments on each posedge with reset = 1 until it equals FILL, then holds. `fill_done` = (cnt == FILL).
- Push request on a posedge requires `fill_done` = 1 before that edge. When fill_done = 1 there is a push request on every edge.
- Average: avg = (s_in + 2) >> 2, computed at W+3 bits and truncated to W bits.
  - Max s_in = 4·(2^W − 1) gives 2^W − 1, so saturation is never needed.
- Pop: occurs on an edge when out_valid = 1 and out_ready = 1.
- Push acceptance: push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs on the same edge. The full-and-popping case leaves count unchanged.
- Rejected push: the sample is discarded, FIFO contents are unchanged, overflow ← 1, and drop_cnt increments unless it is already 255.
- Push + pop on the same edge with 0 < count < DEPTH: count unchanged, both pointers advance.
- Empty FIFO with push: the entry is written. out_valid rises after the edge and the new entry is the head.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately to distinguish full from empty.
- Reset (at any time, including mid-burst):
  - fill counter, pointers, count, overflow and drop_cnt go to 0.
  - out_valid = 0 and out_data = 0.
  - FIFO storage is not reset, and buffered entries are lost.
  - The fill sequence restarts.

## Timing
- Reset values: out_data 0, out_valid 0, fill_done 0, count 0, overflow 0, drop_cnt 0.
- Fill sequence after reset goes 0→1 on edge R:
  - fill_done = 1 after edge R+FILL−1, counting edge R as the first edge with reset high.
  - The first push happens at edge R+FILL.
- Latency: s_in sampled at edge k into an empty FIFO → out_data/out_valid valid immediately after edge k. This is one register stage, and out_data comes combinationally from the head entry.
- out_data is stable while out_valid = 1 and out_ready = 0, unless a reset occurs.
- overflow, count and drop_cnt update on the same edge as the push/pop decision that changes them.
- No combinational path from out_ready to out_valid or out_data.

## Test plan
- Constant fill: reset low 2 cycles, then FIR driven with a = 1000 and out_ready = 1.
  - No push before fill_done.
  - Then s_in = 4000 gives out_data = 1000 every cycle, with count staying ≤ 1.
- Rounding, driving s_in directly:
  - s_in = 5 → 1; s_in = 6 → 2; s_in = 7 → 2.
  - s_in = 0x3FFFC → 0xFFFF; s_in = 0 → 0.
- Overflow, with out_ready = 0, DEPTH = 8, and a ramp s_in = 4, 8, 12, … after fill:
  - count reaches 8 after 8 pushes.
  - The next edge sets overflow = 1 and drop_cnt = 1.
  - After 300 dropped samples, drop_cnt = 255.
  - When out_ready is then raised, the heads read 1, 2, …, 8 in order.
- Full with simultaneous pop: with count = 8, out_ready pulsed for 1 cycle while a push arrives.
  - count stays 8, overflow is not set, the oldest entry leaves and the newest is written at the tail.
- Reset mid-operation: with count = 5 and overflow = 1, assert reset for 1 edge.
  - All outputs return to their reset values.
  - fill_done reasserts exactly FILL edges after release, and stale entries never appear on out_data.
- Wrap-around: push/pop pointers both cross index DEPTH−1→0 at least 3 times with random out_ready (50%).
  - Output stream equals the reference-model averages in order, with no drops whenever count < DEPTH.
